delay_sched: RTL and testbench
==============================

# delay_sched

Shared delay-timer scheduler. Several requesters each need a fixed N+1-cycle delay but the design carries only one CBITS-wide delay counter. This block arbitrates among the requesters, sequences the counter for the winner, and returns a one-cycle completion pulse to that winner. It sits between the client FSMs and the delay datapath and replaces per-client free-running delay counters.

## Interface
- NREQ, 4, number of requesters (2..8)
- N, 25000, terminal count; delay spans counts 0..N inclusive; must satisfy N < 2^CBITS
- CBITS, 15, counter width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  level request per requester; held until its sig pulse
- abort  in  1  cancels the delay in progress, no completion pulse
- gnt  out  NREQ  one-hot owner of the timer; all-zero when idle
- sig  out  NREQ  one-cycle completion pulse to the owner
- busy  out  1  high in RUN and DONE
- err  out  1  sticky protocol-violation flag
- cnt  out  CBITS  current count

## Operation
- Reset, asynchronous: state IDLE, gnt=0, sig=0, busy=0, err=0, cnt=0, round-robin pointer=NREQ-1.
- IDLE: if req!=0, select a winner; next edge: gnt=onehot(winner), cnt=0, busy=1, state RUN. No requests: stay in IDLE.
- RUN: cnt increments by 1 each cycle. When cnt==N: next edge goes to DONE, cnt holds at N, sig=gnt.
- DONE: lasts one cycle with sig asserted and gnt held. Next edge: sig=0, gnt=0, busy=0, cnt=0, state IDLE. No arbitration in DONE.
- Owner drops req during RUN: next edge goes to IDLE, gnt=0, cnt=0, no sig, err=1.
- abort during RUN: next edge goes to IDLE, no sig, err unchanged. abort has no effect in IDLE or DONE.
- If abort and an owner req drop occur in the same cycle, the req drop wins and err is set.
- Requests from non-owners during RUN/DONE are ignored. They are not latched and are re-evaluated in IDLE.
- err clears only on rst.
- cnt never exceeds N. The comparison is equality against N at CBITS width.

## Timing
- Request seen in IDLE at cycle T: gnt at T+1, cnt=0..N over cycles T+1..T+N+1, sig at T+N+2, gnt/busy low at T+N+3.
- Earliest next grant: T+N+4. Each grant costs N+3 cycles, including the idle arbitration cycle.
- Owner may drop req in its sig cycle or later. Dropping it in the DONE cycle is not a violation.
- All outputs are registered. Reset assertion clears them without waiting for a clock edge.

## Configuration
- DELAY_SCHED_RR_EN defined: round-robin arbitration. Search starts at pointer+1 modulo NREQ. The pointer updates to the winner index on each grant.
- DELAY_SCHED_RR_EN undefined: fixed priority, lowest index wins. The pointer logic is absent.

## Test plan
- NREQ=4, N=4, req=0001 from cycle 0 -> gnt=0001 at cycles 1..6; cnt 0,1,2,3,4 at cycles 1..5; sig=0001 only at cycle 6; gnt=0 and busy=0 at cycle 7.
- req=1111 held throughout, each requester dropping req one cycle after its sig and re-raising it -> with RR_EN grant order is 0,1,2,3,0; without RR_EN it is 0,0,0.
- Owner 2 drops req when cnt=2 -> gnt=0 next cycle; no sig; err=1 and stays 1 through later clean delays.
- abort pulse when cnt=3 -> IDLE next cycle; no sig; err=0; a pending req=0100 is granted the following cycle.
- rst pulsed mid-RUN between clock edges -> gnt, sig, busy, cnt are 0 before the next edge. After release, with RR_EN, req=1010 grants index 1.
- N=2^CBITS-1 with CBITS=4 (N=15), single request -> sig after cnt reaches 15; no wrap to 0 before DONE.

Source files
------------

// File: rtl/delay_sched.sv
// Shared delay-timer scheduler: arbitrates requesters onto one delay counter and pulses sig on completion.
// Define DELAY_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module delay_sched #(
    parameter int NREQ  = 4,
    parameter int N     = 25000,
    parameter int CBITS = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             abort,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  sig,
    output logic             busy,
    output logic             err,
    output logic [CBITS-1:0] cnt
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CBITS-1:0] TERM = CBITS'(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NREQ-1:0]   gnt_nxt;
    logic [NREQ-1:0]   sig_nxt;
    logic              busy_nxt;
    logic              err_nxt;
    logic [CBITS-1:0]  cnt_nxt;
    logic              win_valid;
    logic [IW-1:0]     win_idx;

`ifdef DELAY_SCHED_RR_EN
    logic [IW-1:0]     ptr;
    logic [IW:0]       cand;

    // Search starts just after the last winner and wraps, so the previous owner is checked last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i + 1);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (!win_valid && req[cand[IW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= IW'(NREQ - 1);
        else if (state == IDLE && win_valid)
            ptr <= win_idx;
    end
`else
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_valid && req[i]) begin
                win_valid = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sig   <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sig   <= sig_nxt;
            busy  <= busy_nxt;
            err   <= err_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // An owner dropping its request outranks abort, and both outrank reaching the terminal count.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sig_nxt   = '0;
        busy_nxt  = busy;
        err_nxt   = err;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nxt = RUN;
                    gnt_nxt   = NREQ'(1) << win_idx;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                if ((req & gnt) == '0) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                end else if (abort) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end else if (cnt == TERM) begin
                    state_nxt = DONE;
                    sig_nxt   = gnt;
                end else begin
                    cnt_nxt   = cnt + CBITS'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched: a narrow-delay instance (N=4) and a full-range counter instance (N=15, CBITS=4).
module tb_delay_sched;
    localparam int NREQ   = 4;
    localparam int N      = 4;
    localparam int CBITS  = 3;
    localparam int N2     = 15;
    localparam int CBITS2 = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic              abort;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   sig;
    logic              busy;
    logic              err;
    logic [CBITS-1:0]  cnt;

    logic [1:0]        req2;
    logic              abort2;
    logic [1:0]        gnt2;
    logic [1:0]        sig2;
    logic              busy2;
    logic              err2;
    logic [CBITS2-1:0] cnt2;

    int nChecks = 0;
    int nFails  = 0;
    int expOrder [5];

    always #5 clk = ~clk;

    delay_sched #(.NREQ(NREQ), .N(N), .CBITS(CBITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .abort (abort),
        .gnt   (gnt),
        .sig   (sig),
        .busy  (busy),
        .err   (err),
        .cnt   (cnt)
    );

    delay_sched #(.NREQ(2), .N(N2), .CBITS(CBITS2)) dutWide (
        .clk   (clk),
        .rst   (rst),
        .req   (req2),
        .abort (abort2),
        .gnt   (gnt2),
        .sig   (sig2),
        .busy  (busy2),
        .err   (err2),
        .cnt   (cnt2)
    );

    // Every comparison funnels through here so the counters stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive inputs for the current cycle, then move to just after the next rising edge.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic a);
        req   = r;
        abort = a;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        req    = '0;
        abort  = 1'b0;
        req2   = '0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef DELAY_SCHED_RR_EN
        expOrder = '{0, 1, 2, 3, 0};
`else
        expOrder = '{0, 0, 0, 0, 0};
`endif
        req    = '0;
        abort  = 1'b0;
        req2   = '0;
        abort2 = 1'b0;
        rst    = 1'b0;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #2;
        checkOutput("reset gnt", gnt, 0);
        checkOutput("reset sig", sig, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset cnt", cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single request timing");
        for (int c = 1; c <= 7; c++) begin
            applyStimulus((c - 1 <= 5) ? 4'b0001 : 4'b0000, 1'b0);
            checkOutput($sformatf("t1 gnt c%0d", c), gnt, (c <= 6) ? 1 : 0);
            checkOutput($sformatf("t1 cnt c%0d", c), cnt, (c <= 5) ? c - 1 : ((c == 6) ? 4 : 0));
            checkOutput($sformatf("t1 sig c%0d", c), sig, (c == 6) ? 1 : 0);
            checkOutput($sformatf("t1 busy c%0d", c), busy, (c <= 6) ? 1 : 0);
        end
        checkOutput("t1 err", err, 0);

        $display("[TB] contending requests");
        doReset();
        for (int g = 0; g < 5; g++) begin
            logic [NREQ-1:0] oh;
            oh = 4'b0001 << expOrder[g];
            applyStimulus(4'b1111, 1'b0);
            checkOutput($sformatf("t2 gnt g%0d", g), gnt, oh);
            checkOutput($sformatf("t2 cnt0 g%0d", g), cnt, 0);
            repeat (N) applyStimulus(4'b1111, 1'b0);
            checkOutput($sformatf("t2 cntN g%0d", g), cnt, N);
            applyStimulus(4'b1111, 1'b0);
            checkOutput($sformatf("t2 sig g%0d", g), sig, oh);
            applyStimulus(4'b1111 & ~oh, 1'b0);
            checkOutput($sformatf("t2 idle g%0d", g), gnt, 0);
            checkOutput($sformatf("t2 err g%0d", g), err, 0);
        end

        $display("[TB] owner drops request");
        doReset();
        applyStimulus(4'b0100, 1'b0);
        checkOutput("t3 gnt", gnt, 4'b0100);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("t3 cnt2", cnt, 2);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t3 drop gnt", gnt, 0);
        checkOutput("t3 drop sig", sig, 0);
        checkOutput("t3 drop err", err, 1);
        checkOutput("t3 drop busy", busy, 0);
        checkOutput("t3 drop cnt", cnt, 0);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("t3 regrant", gnt, 4'b0001);
        repeat (N) applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("t3 clean sig", sig, 4'b0001);
        checkOutput("t3 err held", err, 1);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t3 err sticky", err, 1);

        $display("[TB] abort");
        doReset();
        checkOutput("t4 err cleared", err, 0);
        applyStimulus(4'b0101, 1'b0);
        checkOutput("t4 gnt", gnt, 4'b0001);
        repeat (3) applyStimulus(4'b0101, 1'b0);
        checkOutput("t4 cnt3", cnt, 3);
        applyStimulus(4'b0101, 1'b1);
        checkOutput("t4 abort gnt", gnt, 0);
        checkOutput("t4 abort sig", sig, 0);
        checkOutput("t4 abort err", err, 0);
        checkOutput("t4 abort busy", busy, 0);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("t4 pending gnt", gnt, 4'b0100);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("t4 cnt1", cnt, 1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t4 both gnt", gnt, 0);
        checkOutput("t4 both err", err, 1);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t4 idle abort gnt", gnt, 4'b0001);
        checkOutput("t4 idle abort cnt", cnt, 0);

        $display("[TB] reset mid-run");
        doReset();
        checkOutput("t5 err cleared", err, 0);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("t5 gnt", gnt, 4'b0010);
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("t5 cnt2", cnt, 2);
        rst = 1'b1;
        #2;
        checkOutput("t5 async gnt", gnt, 0);
        checkOutput("t5 async sig", sig, 0);
        checkOutput("t5 async busy", busy, 0);
        checkOutput("t5 async cnt", cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b1010, 1'b0);
        checkOutput("t5 post gnt", gnt, 4'b0010);

        $display("[TB] full-range counter");
        doReset();
        for (int c = 1; c <= 18; c++) begin
            req2 = (c - 1 <= 16) ? 2'b01 : 2'b00;
            applyStimulus(4'b0000, 1'b0);
            checkOutput($sformatf("t6 gnt c%0d", c), gnt2, (c <= 17) ? 1 : 0);
            checkOutput($sformatf("t6 cnt c%0d", c), cnt2, (c <= 16) ? c - 1 : ((c == 17) ? 15 : 0));
            checkOutput($sformatf("t6 sig c%0d", c), sig2, (c == 17) ? 1 : 0);
            checkOutput($sformatf("t6 busy c%0d", c), busy2, (c <= 17) ? 1 : 0);
        end
        checkOutput("t6 err", err2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
